// File: rtl/vcache_stat_trigger.sv
// rtl/vcache_stat_trigger.sv - vcache stats-dump producer: cycle counter, queued print-stat strobes with enforced gap.
// Optional trace printing is enabled by defining VCACHE_STAT_TRIGGER_TRACE_EN.
module vcache_stat_trigger #(
    parameter int data_width_p = 32,
    parameter int els_p        = 4,
    parameter int gap_p        = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [data_width_p-1:0] tag_i,
    output logic                    ready_o,
    output logic [31:0]             global_ctr_o,
    output logic                    print_stat_v_o,
    output logic [data_width_p-1:0] print_stat_tag_o,
    output logic                    busy_o,
    output logic [31:0]             emit_count_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int gap_w = (gap_p > 1) ? $clog2(gap_p) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e                  state_q;
    logic [gap_w-1:0]        gap_cnt_q;
    logic [31:0]             global_ctr_q;
    logic [31:0]             emit_count_q;
    logic                    print_v_q;
    logic [data_width_p-1:0] print_tag_q;

    logic [data_width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]        rptr_q;
    logic [ptr_w-1:0]        wptr_q;
    logic [ptr_w:0]          count_q;

    logic                    full;
    logic                    empty;
    logic                    enq;
    logic                    deq;
    logic [ptr_w-1:0]        rptr_nxt;
    logic [ptr_w:0]          count_after;
    logic [data_width_p-1:0] head_after;

    assign full        = (count_q == (ptr_w+1)'(els_p));
    assign empty       = (count_q == '0);
    assign enq         = v_i & ~full;
    assign deq         = (state_q == EMIT);
    assign rptr_nxt    = rptr_q + ptr_w'(1);
    assign count_after = count_q - (ptr_w+1)'(1) + (ptr_w+1)'(enq);
    // With a single entry left, the next head is the word being written this cycle.
    assign head_after  = (count_q > (ptr_w+1)'(1)) ? mem[rptr_nxt] : tag_i;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr_q] <= tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + ptr_w'(1);
            if (deq) rptr_q <= rptr_nxt;
            count_q <= count_q + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            global_ctr_q <= '0;
            emit_count_q <= '0;
            print_v_q    <= 1'b0;
            print_tag_q  <= '0;
        end else begin
            global_ctr_q <= global_ctr_q + 32'd1;
            print_v_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q     <= EMIT;
                        print_v_q   <= 1'b1;
                        print_tag_q <= mem[rptr_q];
                    end
                end
                EMIT: begin
                    emit_count_q <= emit_count_q + 32'd1;
                    if (gap_p > 0) begin
                        state_q   <= GAP;
                        gap_cnt_q <= gap_w'((gap_p > 0) ? gap_p - 1 : 0);
                    end else if (count_after != '0) begin
                        state_q     <= EMIT;
                        print_v_q   <= 1'b1;
                        print_tag_q <= head_after;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        if (!empty) begin
                            state_q     <= EMIT;
                            print_v_q   <= 1'b1;
                            print_tag_q <= mem[rptr_q];
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - gap_w'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef VCACHE_STAT_TRIGGER_TRACE_EN
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (state_q == EMIT) begin
                $display("[BSG_INFO][VCACHE_STAT_TRIGGER] t=%0t tag=%0h ctr=%0d n=%0d",
                         $time, print_tag_q, global_ctr_q, emit_count_q);
            end
            if (v_i && !ready_o) begin
                $display("[BSG_WARN][VCACHE_STAT_TRIGGER] t=%0t request backpressured, queue full", $time);
            end
        end
    end
`endif

    assign ready_o          = ~full;
    assign busy_o           = ~empty | (state_q != IDLE);
    assign global_ctr_o     = global_ctr_q;
    assign emit_count_o     = emit_count_q;
    assign print_stat_v_o   = print_v_q;
    assign print_stat_tag_o = print_tag_q;

endmodule

// File: tb/tb_vcache_stat_trigger.sv
// tb/tb_vcache_stat_trigger.sv - directed self-checking bench for vcache_stat_trigger (gap 4 and gap 0 instances).
module tb_vcache_stat_trigger;

    logic        clk = 1'b0;
    logic        resetn;
    logic        v, v0;
    logic [31:0] tag, tag0;

    logic        ready, pv, busy;
    logic [31:0] ctr, ptag, emit;
    logic        ready0, pv0, busy0;
    logic [31:0] ctr0, ptag0, emit0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    vcache_stat_trigger #(.data_width_p(32), .els_p(4), .gap_p(4)) dut (
        .clk_i(clk), .reset_n_i(resetn), .v_i(v), .tag_i(tag), .ready_o(ready),
        .global_ctr_o(ctr), .print_stat_v_o(pv), .print_stat_tag_o(ptag),
        .busy_o(busy), .emit_count_o(emit)
    );

    vcache_stat_trigger #(.data_width_p(32), .els_p(4), .gap_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(resetn), .v_i(v0), .tag_i(tag0), .ready_o(ready0),
        .global_ctr_o(ctr0), .print_stat_v_o(pv0), .print_stat_tag_o(ptag0),
        .busy_o(busy0), .emit_count_o(emit0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    initial begin
        resetn = 1'b0; v = 1'b0; tag = '0; v0 = 1'b0; tag0 = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // First post-reset cycle
        chk("rst_ctr", ctr, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pv", {31'd0, pv}, 32'd0);
        chk("rst_ptag", ptag, 32'd0);
        chk("rst_emit", emit, 32'd0);
        chk("rst_ready0", {31'd0, ready0}, 32'd1);

        for (int i = 1; i <= 100; i++) begin
            step();
            chk("idle_ctr", ctr, 32'(i));
            chk("idle_pv", {31'd0, pv}, 32'd0);
        end

        // Single request: accepted in c, strobe in c+2
        v = 1'b1; tag = 32'hA5;
        step(); v = 1'b0;
        chk("single_c1_pv", {31'd0, pv}, 32'd0);
        chk("single_c1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("single_c2_pv", {31'd0, pv}, 32'd1);
        chk("single_c2_tag", ptag, 32'hA5);
        step();
        chk("single_c3_pv", {31'd0, pv}, 32'd0);
        chk("single_c3_emit", emit, 32'd1);
        chk("single_c3_taghold", ptag, 32'hA5);
        repeat (3) step();
        chk("single_c6_busy", {31'd0, busy}, 32'd1);
        step();
        chk("single_c7_busy", {31'd0, busy}, 32'd0);

        // Priming request, then a burst of 5 during its gap
        v = 1'b1; tag = 32'h77;
        step(); v = 1'b0;
        step();
        chk("prime_pv", {31'd0, pv}, 32'd1);
        chk("prime_tag", ptag, 32'h77);
        step();
        for (int k = 0; k < 30; k++) begin
            if (k < 4) begin
                v = 1'b1; tag = 32'(k + 1);
            end else if (k == 4 || k == 5) begin
                v = 1'b1; tag = 32'd5;
            end else begin
                v = 1'b0; tag = '0;
            end
            if (k == 4) chk("burst_ready_full", {31'd0, ready}, 32'd0);
            if (k == 5) chk("burst_ready_freed", {31'd0, ready}, 32'd1);
            if (k == 6) chk("burst_ready_refull", {31'd0, ready}, 32'd0);
            if (k == 10) chk("burst_ready_drain", {31'd0, ready}, 32'd1);
            if (k >= 4 && k <= 24 && ((k - 4) % 5 == 0)) begin
                chk("burst_pv", {31'd0, pv}, 32'd1);
                chk("burst_tag", ptag, 32'((k - 4) / 5 + 1));
            end else begin
                chk("burst_pv_low", {31'd0, pv}, 32'd0);
            end
            if (k == 29) chk("burst_busy_end", {31'd0, busy}, 32'd0);
            step();
        end
        chk("burst_emit", emit, 32'd7);

        // gap_p = 0: three back-to-back strobes
        v0 = 1'b1; tag0 = 32'h11;
        step(); tag0 = 32'h22;
        step(); tag0 = 32'h33;
        chk("g0_pv1", {31'd0, pv0}, 32'd1);
        chk("g0_tag1", ptag0, 32'h11);
        step(); v0 = 1'b0;
        chk("g0_pv2", {31'd0, pv0}, 32'd1);
        chk("g0_tag2", ptag0, 32'h22);
        step();
        chk("g0_pv3", {31'd0, pv0}, 32'd1);
        chk("g0_tag3", ptag0, 32'h33);
        step();
        chk("g0_pv_end", {31'd0, pv0}, 32'd0);
        chk("g0_emit", emit0, 32'd3);
        chk("g0_busy", {31'd0, busy0}, 32'd0);

        // Reset during GAP with two entries queued
        v = 1'b1; tag = 32'hAA;
        step(); tag = 32'hBB;
        step(); tag = 32'hCC;
        chk("rg_pv", {31'd0, pv}, 32'd1);
        chk("rg_tag", ptag, 32'hAA);
        step(); v = 1'b0;
        chk("rg_gap_pv", {31'd0, pv}, 32'd0);
        chk("rg_gap_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        step(); resetn = 1'b1;
        chk("rg_ctr", ctr, 32'd0);
        chk("rg_pv_after", {31'd0, pv}, 32'd0);
        chk("rg_ready", {31'd0, ready}, 32'd1);
        chk("rg_busy", {31'd0, busy}, 32'd0);
        chk("rg_emit", emit, 32'd0);
        chk("rg_ptag", ptag, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("rg_post_pv", {31'd0, pv}, 32'd0);
            chk("rg_post_ctr", ctr, 32'(k));
        end
        chk("rg_post_busy", {31'd0, busy}, 32'd0);

        // global counter wrap across a strobe
        force dut.global_ctr_q = 32'hFFFF_FFFD;
        #1;
        release dut.global_ctr_q;
        chk("wrap_pre", ctr, 32'hFFFF_FFFD);
        v = 1'b1; tag = 32'hC3;
        step(); v = 1'b0;
        chk("wrap_c1", ctr, 32'hFFFF_FFFE);
        step();
        chk("wrap_strobe_pv", {31'd0, pv}, 32'd1);
        chk("wrap_strobe_ctr", ctr, 32'hFFFF_FFFF);
        chk("wrap_strobe_tag", ptag, 32'hC3);
        step();
        chk("wrap_zero", ctr, 32'd0);
        chk("wrap_emit", emit, 32'd1);
        repeat (5) step();

        // emit counter wrap
        force dut.emit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.emit_count_q;
        chk("ewrap_pre", emit, 32'hFFFF_FFFF);
        v = 1'b1; tag = 32'h5A;
        step(); v = 1'b0;
        step();
        chk("ewrap_pv", {31'd0, pv}, 32'd1);
        chk("ewrap_tag", ptag, 32'h5A);
        step();
        chk("ewrap_emit", emit, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
